int_ctrl: RTL and testbench
===========================

Name: int_ctrl

Overview:
- Interrupt controller that drives the CPU's single interrupt request line `ir1`.
- Collects N edge-triggered peripheral interrupt sources, latches them as pending, and applies per-source masking and fixed priority.
- Raises `ir1` to the monocycle CPU and holds it until the CPU acknowledges.
- Supplies the handler vector, then blocks further requests until the CPU signals end-of-interrupt (on return from the handler).

Parameters:
- N_SRC, 4, number of interrupt sources (2..8).
- VEC_W, 10, width of the vector output; matches the CPU program-counter width.
- VEC_BASE, 10'h3C0, address of the source-0 handler.
- VEC_STRIDE_LOG2, 2, log2 of the address spacing between handler entries.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- irq_src  input  N_SRC  peripheral interrupt lines; each rising edge is one request.
- mask  input  N_SRC  1 = source blocked from raising `ir1`; its pending bit is still recorded.
- ir1  output  1  interrupt request to the CPU; registered.
- iack  input  1  one-cycle acknowledge pulse from the CPU.
- eoi  input  1  one-cycle end-of-interrupt pulse from the CPU (return from handler).
- vector  output  VEC_W  handler address for the serviced source; registered.
- active_id  output  3  index of the source in service.
- busy  output  1  1 while in SERVICE.
- pending  output  N_SRC  current pending bits, for debug/status.

Behaviour:
- **Reset.** Synchronous and active-high. While `reset`=1 at a rising edge, all registers clear:
  - outputs: `ir1`=0, `vector`=0, `active_id`=0, `busy`=0, `pending`=0;
  - internal: state=IDLE, `irq_prev`=0.
  - Reset mid-REQ or mid-SERVICE abandons the interrupt. No pending bit survives.
- **Edge detect.** `irq_prev` <= `irq_src` each cycle. `rise[i]` = `irq_src[i]` & ~`irq_prev[i]`.
  - A rising edge sets `pending[i]` at that clock edge.
  - A level held high produces only one request.
- **Eligibility and priority.** `elig` = `pending` & ~`mask`. Fixed priority: the lowest index wins.
- **FSM states:** IDLE, REQ, SERVICE.
  - **IDLE:** if `elig`≠0, go to REQ. Otherwise stay.
  - **REQ:**
    - On `iack`=1: select the winner from `elig` in that same cycle and latch `active_id`=winner. Latch `vector` = VEC_BASE + (winner << VEC_STRIDE_LOG2), truncated to VEC_W. Clear `pending[winner]`. Go to SERVICE.
    - On `iack`=0 with `elig`=0 (masked away): return to IDLE. `ir1` drops the following cycle.
  - **SERVICE:** on `eoi`=1, go to IDLE. `vector` and `active_id` hold their values until the next `iack`.
- **Registered outputs.** `ir1` = (next state == REQ), so it is high exactly in the cycles the FSM is in REQ. `busy` = (state == SERVICE).
- **Latency.**
  - Source rise sampled at edge k → `pending` set after edge k → `ir1`=1 after edge k+1.
  - `iack` at edge m → `ir1`=0 and `busy`=1 after edge m.
  - `eoi` at edge p → `busy`=0 after edge p; a further pending request raises `ir1` after edge p+1.
- **No nesting.** New edges arriving during REQ or SERVICE still set pending bits but never change the source in service.
- **Ignored strobes.** `iack` outside REQ is ignored. `eoi` outside SERVICE is ignored.
- **Same-bit set and clear.** If a new rise and the iack-clear hit the same bit in one cycle, the set wins: the bit stays pending.
- **Simultaneous rises.** Multiple sources rising in one cycle are all recorded and then serviced one by one in priority order.
- **Re-arm.** A source that falls and rises again while already pending is counted once; requests are not queued per source.

Test Plan:
- Reset mid-SERVICE: `reset`=1 for one cycle → next cycle `busy`=0, `ir1`=0, `pending`=0. A subsequent `eoi` has no effect.
- Single source: `irq_src`=4'b0100 held high, `mask`=0.
  - `ir1`=1 two edges later and stays high through 3 idle cycles.
  - `iack` pulse → `vector`=10'h3C8, `active_id`=2, `busy`=1, `ir1`=0, `pending`=0.
  - `eoi` → `busy`=0, and `ir1` stays 0 because the level is held but there is no new edge.
- Priority: `irq_src` 0→4'b1010 in one cycle.
  - First `iack` → `active_id`=1, `vector`=10'h3C4.
  - After `eoi`, `ir1` rises again. Second `iack` → `active_id`=3, `vector`=10'h3CC, `pending`=0.
- Masking: `mask`=4'b0001 with a rise on source 0 → `pending`=4'b0001 and `ir1` stays 0 for 10 cycles. Clearing `mask` → `ir1`=1 one cycle later. Setting `mask` again while in REQ without `iack` → `ir1` returns to 0.
- Arrival during SERVICE: source 3 in service, source 0 rises → `pending`=4'b0001, `active_id` stays 3, `ir1` stays 0 until `eoi`. After `eoi`, `ir1`=1 within 1 cycle and the next `iack` gives `active_id`=0.
- Stray strobes and set-wins collision:
  - `iack` in IDLE and `eoi` in REQ → no state change.
  - A rise on the winning source in the same cycle as its `iack` → `pending[winner]` remains 1.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: edge-triggered, maskable, fixed-priority interrupt controller
// that drives the single CPU request line ir1 and supplies the handler
// vector on acknowledge.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   irq_src [N_SRC]  peripheral request lines (rising edge = request)
//   mask    [N_SRC]  1 = source cannot raise ir1 (still recorded)
//   iack, eoi        CPU acknowledge / end-of-interrupt pulses
//   ir1              registered interrupt request to the CPU
//   vector [VEC_W]   handler address of the source in service
//   active_id [3]    index of the source in service
//   busy             high while a handler is running
//   pending [N_SRC]  latched request bits
module int_ctrl #(
  parameter int               N_SRC           = 4,
  parameter int               VEC_W           = 10,
  parameter logic [VEC_W-1:0] VEC_BASE        = 10'h3C0,
  parameter int               VEC_STRIDE_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [N_SRC-1:0] mask,
  output logic             ir1,
  input  logic             iack,
  input  logic             eoi,
  output logic [VEC_W-1:0] vector,
  output logic [2:0]       active_id,
  output logic             busy,
  output logic [N_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   irq_prev_q;
  logic [N_SRC-1:0]   pending_q;
  logic               ir1_q;
  logic               busy_q;
  logic [2:0]         active_id_q;
  logic [VEC_W-1:0]   vector_q;

  logic [N_SRC-1:0]   rise;
  logic [N_SRC-1:0]   elig;
  logic [N_SRC-1:0]   win_oh;
  logic [N_SRC-1:0]   clr;
  logic [2:0]         win_id;
  logic [VEC_W-1:0]   vec_d;
  logic               take;

  assign rise = irq_src & ~irq_prev_q;
  assign elig = pending_q & ~mask;

  // Two's-complement trick isolates the lowest set bit: lowest index wins.
  assign win_oh = elig & (~elig + N_SRC'(1));

  always_comb begin
    win_id = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (win_oh[i]) win_id = 3'(i);
    end
  end

  assign take  = (state_q == REQ) && iack && (|elig);
  assign clr   = take ? win_oh : '0;
  assign vec_d = VEC_BASE + (VEC_W'(win_id) << VEC_STRIDE_LOG2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (|elig) state_d = REQ;
      end
      REQ: begin
        if (take)         state_d = SERVICE;
        else if (~|elig)  state_d = IDLE;
      end
      SERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      irq_prev_q  <= '0;
      pending_q   <= '0;
      ir1_q       <= 1'b0;
      busy_q      <= 1'b0;
      active_id_q <= '0;
      vector_q    <= '0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_src;
      // A new edge on the bit being cleared keeps it pending.
      pending_q  <= (pending_q & ~clr) | rise;
      ir1_q      <= (state_d == REQ);
      busy_q     <= (state_d == SERVICE);
      if (take) begin
        active_id_q <= win_id;
        vector_q    <= vec_d;
      end
    end
  end

  assign ir1       = ir1_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign active_id = active_id_q;
  assign vector    = vector_q;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  logic [3:0] mask;
  logic       iack;
  logic       eoi;
  logic       ir1;
  logic [9:0] vector;
  logic [2:0] active_id;
  logic       busy;
  logic [3:0] pending;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  int_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .mask      (mask),
    .ir1       (ir1),
    .iack      (iack),
    .eoi       (eoi),
    .vector    (vector),
    .active_id (active_id),
    .busy      (busy),
    .pending   (pending)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset   = 1'b1;
    irq_src = '0;
    mask    = '0;
    iack    = 1'b0;
    eoi     = 1'b0;
    tick(2);
    reset = 1'b0;
    chk("rst_ir1", 32'(ir1), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_vec", 32'(vector), 0);
    chk("rst_id", 32'(active_id), 0);

    // single source, level held
    irq_src = 4'b0100;
    tick();
    chk("s_pend", 32'(pending), 32'h4);
    chk("s_ir1_early", 32'(ir1), 0);
    tick();
    chk("s_ir1", 32'(ir1), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s_ir1_hold", 32'(ir1), 1);
    end
    iack = 1'b1;
    tick();
    iack = 1'b0;
    chk("s_vec", 32'(vector), 32'h3C8);
    chk("s_id", 32'(active_id), 2);
    chk("s_busy", 32'(busy), 1);
    chk("s_ir1_ack", 32'(ir1), 0);
    chk("s_pend_ack", 32'(pending), 0);
    tick(2);
    chk("s_busy_hold", 32'(busy), 1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("s_busy_eoi", 32'(busy), 0);
    tick(2);
    chk("s_no_rearm", 32'(ir1), 0);
    chk("s_vec_hold", 32'(vector), 32'h3C8);
    irq_src = '0;
    tick();

    // reset mid-SERVICE
    irq_src = 4'b0001;
    tick(2);
    chk("r_ir1", 32'(ir1), 1);
    iack = 1'b1;
    tick();
    iack = 1'b0;
    chk("r_busy", 32'(busy), 1);
    reset   = 1'b1;
    irq_src = '0;
    tick();
    reset = 1'b0;
    chk("r_busy_clr", 32'(busy), 0);
    chk("r_ir1_clr", 32'(ir1), 0);
    chk("r_pend_clr", 32'(pending), 0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("r_eoi_busy", 32'(busy), 0);
    chk("r_eoi_ir1", 32'(ir1), 0);

    // simultaneous rises, priority order
    irq_src = 4'b1010;
    tick();
    chk("p_pend", 32'(pending), 32'hA);
    tick();
    chk("p_ir1", 32'(ir1), 1);
    iack = 1'b1;
    tick();
    iack = 1'b0;
    chk("p_id1", 32'(active_id), 1);
    chk("p_vec1", 32'(vector), 32'h3C4);
    chk("p_pend1", 32'(pending), 32'h8);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("p_busy_eoi", 32'(busy), 0);
    chk("p_ir1_gap", 32'(ir1), 0);
    tick();
    chk("p_ir1_again", 32'(ir1), 1);
    iack = 1'b1;
    tick();
    iack = 1'b0;
    chk("p_id3", 32'(active_id), 3);
    chk("p_vec3", 32'(vector), 32'h3CC);
    chk("p_pend3", 32'(pending), 0);

    // arrival during SERVICE (source 3 in service)
    irq_src = 4'b1011;
    tick();
    chk("a_pend", 32'(pending), 32'h1);
    chk("a_id", 32'(active_id), 3);
    chk("a_busy", 32'(busy), 1);
    tick(2);
    chk("a_ir1_blk", 32'(ir1), 0);
    chk("a_id_hold", 32'(active_id), 3);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    chk("a_ir1", 32'(ir1), 1);
    iack = 1'b1;
    tick();
    iack = 1'b0;
    chk("a_id0", 32'(active_id), 0);
    chk("a_vec0", 32'(vector), 32'h3C0);
    eoi = 1'b1;
    tick();
    eoi     = 1'b0;
    irq_src = '0;
    tick();

    // masking
    mask    = 4'b0001;
    irq_src = 4'b0001;
    tick();
    chk("m_pend", 32'(pending), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("m_ir1_blk", 32'(ir1), 0);
    end
    mask = '0;
    tick();
    chk("m_ir1", 32'(ir1), 1);
    mask = 4'b0001;
    tick();
    chk("m_ir1_drop", 32'(ir1), 0);
    chk("m_pend_keep", 32'(pending), 32'h1);

    // stray strobes
    iack = 1'b1;
    tick();
    iack = 1'b0;
    chk("x_iack_busy", 32'(busy), 0);
    chk("x_iack_ir1", 32'(ir1), 0);
    chk("x_iack_pend", 32'(pending), 32'h1);
    mask = '0;
    tick();
    chk("x_ir1", 32'(ir1), 1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("x_eoi_ir1", 32'(ir1), 1);
    chk("x_eoi_busy", 32'(busy), 0);

    // set wins over iack clear on the same bit
    irq_src = '0;
    tick();
    chk("c_ir1", 32'(ir1), 1);
    irq_src = 4'b0001;
    iack    = 1'b1;
    tick();
    iack = 1'b0;
    chk("c_busy", 32'(busy), 1);
    chk("c_id", 32'(active_id), 0);
    chk("c_pend", 32'(pending), 32'h1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    chk("c_ir1_next", 32'(ir1), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
